// File: rtl/adrv9001_ssi_serializer.sv
// ---------------------------------------------------------------------------
// adrv9001_ssi_serializer
//
// Purpose: converts a 32-bit I/Q sample stream into ADRV9001-style SSI serial
// lanes. Each frame carries one 16-bit I sample on idata and one 16-bit Q
// sample on qdata, one bit per clk. The frame strobe is high on the first bit
// (STROBE_LONG=0) or on the first 8 bits (STROBE_LONG=1). When the stream runs
// dry between frames while the channel is enabled, a zero frame is inserted
// and counted.
//
// Optional feature: define ADRV9001_SSI_SER_RAMP_EN to build the internal
// ramp source. With it built and test_mode=1, frames come from a 16-bit ramp
// (I=ramp, Q=~ramp) and the stream is ignored. Without it, test_mode is ignored.
//
// Parameters:
//   MSB_FIRST   1: lane bit 15 first, 0: lane bit 0 first
//   STROBE_LONG 0: strobe on bit 0 only, 1: strobe on bits 0..7
//
// Ports:
//   clk            single clock, one serial bit per rising edge
//   rst            asynchronous active-high reset
//   enable         channel enable (level)
//   s_axis_tdata   [31:16] I sample, [15:0] Q sample
//   s_axis_tvalid  sample word valid
//   s_axis_tready  word accepted this cycle
//   test_mode      select the ramp source (ramp build only)
//   strobe         SSI frame strobe
//   idata / qdata  serial I / Q lanes
//   busy           high while a frame is shifted (state == SHIFT)
//   underflow      one-cycle pulse in the cycle a zero frame is scheduled
//   underflow_cnt  saturating count of inserted zero frames
// ---------------------------------------------------------------------------
module adrv9001_ssi_serializer #(
    parameter int MSB_FIRST   = 1,
    parameter int STROBE_LONG = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        test_mode,
    output logic        strobe,
    output logic        idata,
    output logic        qdata,
    output logic        busy,
    output logic        underflow,
    output logic [15:0] underflow_cnt
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_bit_cnt;
    logic [3:0]  w_bit_cnt_next;
    logic [15:0] r_i_sr;
    logic [15:0] r_q_sr;
    logic [15:0] w_i_sr_next;
    logic [15:0] w_q_sr_next;
    logic        r_strobe;
    logic        r_idata;
    logic        r_qdata;
    logic [15:0] r_underflow_cnt;
    logic        r_run;
    logic        w_ramp_mode;
    logic        w_frame_end;
    logic        w_slot;
    logic        w_load_word;
    logic        w_load_zero;
    logic        w_load_ramp;
    logic        w_load;
    logic        w_strobe_next;
    logic        w_i_bit_next;
    logic        w_q_bit_next;
    logic [31:0] w_load_data;
    logic [31:0] w_ramp_word;

`ifdef ADRV9001_SSI_SER_RAMP_EN
    logic [15:0] r_ramp;

    assign w_ramp_mode = test_mode;
    assign w_ramp_word = {r_ramp, ~r_ramp};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ramp <= 16'd0;
        end else if (w_load_ramp) begin
            r_ramp <= r_ramp + 16'd1;   // wraps 0xFFFF -> 0x0000
        end
    end
`else
    logic w_unused_test_mode;

    assign w_unused_test_mode = test_mode;
    assign w_ramp_mode        = 1'b0;
    assign w_ramp_word        = 32'd0;
`endif

    // r_run is cleared asynchronously and set on the first edge after reset
    // release, so the earliest acceptance is the second edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Handshake: a word transfers on a rising edge where s_axis_tvalid and
    // s_axis_tready are both high. tready depends only on state, bit_cnt,
    // enable and the ramp select -- never on tvalid -- and is offered only in
    // IDLE or in the last bit of a frame, so frames chain without gaps.
    assign w_frame_end   = (r_state == SHIFT) && (r_bit_cnt == 4'd15);
    assign w_slot        = r_run && enable && ((r_state == IDLE) || w_frame_end);
    assign s_axis_tready = w_slot && !w_ramp_mode;
    assign w_load_word   = s_axis_tready && s_axis_tvalid;
    // Zero frames fill gaps only between frames, never from IDLE.
    assign w_load_zero   = s_axis_tready && !s_axis_tvalid && w_frame_end;
    assign w_load_ramp   = w_slot && w_ramp_mode;
    assign w_load        = w_load_word || w_load_zero || w_load_ramp;

    always_comb begin
        w_load_data = s_axis_tdata;
        if (w_load_ramp) begin
            w_load_data = w_ramp_word;
        end else if (w_load_zero) begin
            w_load_data = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_i_sr_next    = r_i_sr;
        w_q_sr_next    = r_q_sr;
        if (w_load) begin
            w_state_next   = SHIFT;
            w_bit_cnt_next = 4'd0;
            w_i_sr_next    = w_load_data[31:16];
            w_q_sr_next    = w_load_data[15:0];
        end else if (r_state == SHIFT) begin
            if (w_frame_end) begin
                w_state_next   = IDLE;
                w_bit_cnt_next = 4'd0;
            end else begin
                w_bit_cnt_next = r_bit_cnt + 4'd1;
                if (MSB_FIRST != 0) begin
                    w_i_sr_next = {r_i_sr[14:0], 1'b0};
                    w_q_sr_next = {r_q_sr[14:0], 1'b0};
                end else begin
                    w_i_sr_next = {1'b0, r_i_sr[15:1]};
                    w_q_sr_next = {1'b0, r_q_sr[15:1]};
                end
            end
        end
    end

    // Output bits are taken from the next shift-register value so the first
    // bit appears on the registered lanes in the cycle right after the load.
    assign w_i_bit_next  = (MSB_FIRST != 0) ? w_i_sr_next[15] : w_i_sr_next[0];
    assign w_q_bit_next  = (MSB_FIRST != 0) ? w_q_sr_next[15] : w_q_sr_next[0];
    assign w_strobe_next = (w_state_next == SHIFT) &&
                           ((w_bit_cnt_next == 4'd0) ||
                            ((STROBE_LONG != 0) && (w_bit_cnt_next < 4'd8)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt       <= 4'd0;
            r_i_sr          <= 16'd0;
            r_q_sr          <= 16'd0;
            r_strobe        <= 1'b0;
            r_idata         <= 1'b0;
            r_qdata         <= 1'b0;
            r_underflow_cnt <= 16'd0;
        end else begin
            r_bit_cnt <= w_bit_cnt_next;
            r_i_sr    <= w_i_sr_next;
            r_q_sr    <= w_q_sr_next;
            r_strobe  <= w_strobe_next;
            r_idata   <= (w_state_next == SHIFT) && w_i_bit_next;
            r_qdata   <= (w_state_next == SHIFT) && w_q_bit_next;
            if (w_load_zero && (r_underflow_cnt != 16'hFFFF)) begin
                r_underflow_cnt <= r_underflow_cnt + 16'd1;
            end
        end
    end

    assign strobe        = r_strobe;
    assign idata         = r_idata;
    assign qdata         = r_qdata;
    assign busy          = (r_state == SHIFT);
    assign underflow     = w_load_zero;
    assign underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_adrv9001_ssi_serializer.sv
// ---------------------------------------------------------------------------
// tb_adrv9001_ssi_serializer
//
// Two instances share all inputs: u_dut_a (MSB first, short strobe) and
// u_dut_b (LSB first, long strobe). Expected lane traces come from a frame
// model built directly from the word values; control expectations (tready,
// underflow, count) are written per scenario from the cycle schedule.
// Cycle convention: inputs change 1 time unit after a rising edge, outputs
// are sampled on the falling edge. A word accepted in cycle c shows bit 0 in
// cycle c+1.
// ---------------------------------------------------------------------------
module tb_adrv9001_ssi_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        test_mode = 1'b0;

    logic        tready_a, strobe_a, idata_a, qdata_a, busy_a, uf_a;
    logic        tready_b, strobe_b, idata_b, qdata_b, busy_b, uf_b;
    logic [15:0] cnt_a, cnt_b;
    logic [21:0] obs_a, obs_b;

    int checks = 0;
    int errors = 0;

    // expected {busy, strobe, idata, qdata} per cycle for each instance
    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];

`ifdef ADRV9001_SSI_SER_RAMP_EN
    localparam logic TM_IGNORED = 1'b0;
`else
    localparam logic TM_IGNORED = 1'b1;
`endif

    always #5 clk = ~clk;

    assign obs_a = {tready_a, uf_a, busy_a, strobe_a, idata_a, qdata_a, cnt_a};
    assign obs_b = {tready_b, uf_b, busy_b, strobe_b, idata_b, qdata_b, cnt_b};

    adrv9001_ssi_serializer #(.MSB_FIRST(1), .STROBE_LONG(0)) u_dut_a (
        .clk(clk), .rst(rst), .enable(enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(tready_a), .test_mode(test_mode),
        .strobe(strobe_a), .idata(idata_a), .qdata(qdata_a),
        .busy(busy_a), .underflow(uf_a), .underflow_cnt(cnt_a)
    );

    adrv9001_ssi_serializer #(.MSB_FIRST(0), .STROBE_LONG(1)) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(tready_b), .test_mode(test_mode),
        .strobe(strobe_b), .idata(idata_b), .qdata(qdata_b),
        .busy(busy_b), .underflow(uf_b), .underflow_cnt(cnt_b)
    );

    // ---------------- reference model ----------------
    task automatic model_frame(input logic [31:0] w);
        logic [15:0] iw;
        logic [15:0] qw;
        iw = w[31:16];
        qw = w[15:0];
        for (int k = 0; k < 16; k++) begin
            exp_a.push_back({1'b1, k == 0, iw[15-k], qw[15-k]});
            exp_b.push_back({1'b1, k < 8, iw[k], qw[k]});
        end
    endtask

    task automatic model_idle(input int n);
        for (int k = 0; k < n; k++) begin
            exp_a.push_back(4'b0000);
            exp_b.push_back(4'b0000);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic en, input logic vl, input logic [31:0] d, input logic tm);
        @(posedge clk);
        #1;
        enable        = en;
        s_axis_tvalid = vl;
        s_axis_tdata  = d;
        test_mode     = tm;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst           = 1'b1;
        enable        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'd0;
        test_mode     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1'b1, 1'b1, $urandom(), 1'b0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== 22'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d] dut_a rdy,uf,busy,stb,i,q=%b cnt=%h expected all zero", c, obs_a[21:16], obs_a[15:0]);
            end
            checks++;
            if (obs_b !== 22'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d] dut_b rdy,uf,busy,stb,i,q=%b cnt=%h expected all zero", c, obs_b[21:16], obs_b[15:0]);
            end
            if (c < 2) @(posedge clk);
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) drive(1'b0, 1'b0, 32'd0, 1'b0);
            @(negedge clk);
            checks++;
            if (obs_a !== 22'd0 || obs_b !== 22'd0) begin
                errors++;
                $display("FAIL reset_release[%0d] dut_a=%h dut_b=%h expected 0", c, obs_a, obs_b);
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] words[2];
        logic [21:0] ev_a, ev_b;
        logic        tm;
        words[0] = 32'h8001_7FFE;
        words[1] = $urandom();
        for (int n = 0; n < 2; n++) begin
            reset_dut();
            tm = (n == 1) ? TM_IGNORED : 1'b0;
            model_idle(1);
            model_frame(words[n]);
            model_idle(4);
            for (int c = 0; c < 21; c++) begin
                drive(c == 0, c == 0, words[n], tm);
                @(negedge clk);
                ev_a = {c == 0, 1'b0, exp_a.pop_front(), 16'h0000};
                ev_b = {c == 0, 1'b0, exp_b.pop_front(), 16'h0000};
                checks++;
                if (obs_a !== ev_a) begin
                    errors++;
                    $display("FAIL single%0d[%0d] dut_a rdy,uf,busy,stb,i,q=%b cnt=%h expected %b cnt=%h", n, c, obs_a[21:16], obs_a[15:0], ev_a[21:16], ev_a[15:0]);
                end
                checks++;
                if (obs_b !== ev_b) begin
                    errors++;
                    $display("FAIL single%0d[%0d] dut_b rdy,uf,busy,stb,i,q=%b cnt=%h expected %b cnt=%h", n, c, obs_b[21:16], obs_b[15:0], ev_b[21:16], ev_b[15:0]);
                end
            end
        end
        test_mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[4];
        logic [21:0] ev_a, ev_b;
        int          idx;
        logic        e_rdy;
        reset_dut();
        model_idle(1);
        for (int f = 0; f < 4; f++) begin
            words[f] = $urandom();
            model_frame(words[f]);
        end
        model_idle(4);
        for (int c = 0; c < 69; c++) begin
            idx = (c <= 48) ? c / 16 : 3;
            drive(c <= 48, c <= 48, words[idx], 1'b0);
            @(negedge clk);
            e_rdy = (c <= 48) && (c % 16 == 0);
            ev_a = {e_rdy, 1'b0, exp_a.pop_front(), 16'h0000};
            ev_b = {e_rdy, 1'b0, exp_b.pop_front(), 16'h0000};
            checks++;
            if (obs_a !== ev_a) begin
                errors++;
                $display("FAIL b2b[%0d] dut_a rdy,uf,busy,stb,i,q=%b cnt=%h expected %b cnt=%h", c, obs_a[21:16], obs_a[15:0], ev_a[21:16], ev_a[15:0]);
            end
            checks++;
            if (obs_b !== ev_b) begin
                errors++;
                $display("FAIL b2b[%0d] dut_b rdy,uf,busy,stb,i,q=%b cnt=%h expected %b cnt=%h", c, obs_b[21:16], obs_b[15:0], ev_b[21:16], ev_b[15:0]);
            end
        end
    endtask

    task automatic test_underflow();
        logic [31:0] w;
        logic [21:0] ev_a, ev_b;
        logic [15:0] e_cnt;
        reset_dut();
        w = $urandom();
        model_idle(1);
        model_frame(w);
        model_frame(32'd0);
        model_idle(4);
        for (int c = 0; c < 37; c++) begin
            drive(c <= 16, c == 0, w, 1'b0);
            @(negedge clk);
            e_cnt = (c >= 17) ? 16'd1 : 16'd0;
            ev_a = {(c == 0) || (c == 16), c == 16, exp_a.pop_front(), e_cnt};
            ev_b = {(c == 0) || (c == 16), c == 16, exp_b.pop_front(), e_cnt};
            checks++;
            if (obs_a !== ev_a) begin
                errors++;
                $display("FAIL underflow[%0d] dut_a rdy,uf,busy,stb,i,q=%b cnt=%h expected %b cnt=%h", c, obs_a[21:16], obs_a[15:0], ev_a[21:16], ev_a[15:0]);
            end
            checks++;
            if (obs_b !== ev_b) begin
                errors++;
                $display("FAIL underflow[%0d] dut_b rdy,uf,busy,stb,i,q=%b cnt=%h expected %b cnt=%h", c, obs_b[21:16], obs_b[15:0], ev_b[21:16], ev_b[15:0]);
            end
        end
    endtask

    // pass 0: enable drops at bit 5 and stays low; pass 1: it returns in the
    // last bit of the frame and the next word follows seamlessly.
    task automatic test_enable();
        logic [31:0] w0, w1;
        logic [21:0] ev_a, ev_b;
        logic        e_rdy;
        int          len;
        for (int p = 0; p < 2; p++) begin
            reset_dut();
            w0 = $urandom();
            w1 = $urandom();
            model_idle(1);
            model_frame(w0);
            if (p == 1) model_frame(w1);
            model_idle(4);
            len = (p == 1) ? 37 : 21;
            for (int c = 0; c < len; c++) begin
                drive((c <= 5) || ((p == 1) && (c == 16)), c <= 16, (c < 16) ? w0 : w1, 1'b0);
                @(negedge clk);
                e_rdy = (c == 0) || ((p == 1) && (c == 16));
                ev_a = {e_rdy, 1'b0, exp_a.pop_front(), 16'h0000};
                ev_b = {e_rdy, 1'b0, exp_b.pop_front(), 16'h0000};
                checks++;
                if (obs_a !== ev_a) begin
                    errors++;
                    $display("FAIL enable%0d[%0d] dut_a rdy,uf,busy,stb,i,q=%b cnt=%h expected %b cnt=%h", p, c, obs_a[21:16], obs_a[15:0], ev_a[21:16], ev_a[15:0]);
                end
                checks++;
                if (obs_b !== ev_b) begin
                    errors++;
                    $display("FAIL enable%0d[%0d] dut_b rdy,uf,busy,stb,i,q=%b cnt=%h expected %b cnt=%h", p, c, obs_b[21:16], obs_b[15:0], ev_b[21:16], ev_b[15:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] w0, w1, w2;
        logic [21:0] ev_a, ev_b;
        logic [15:0] e_cnt;
        reset_dut();
        w0 = $urandom();
        w1 = $urandom() | 32'h0240_0240;   // bit 9 of the frame is 1 on both lanes in both orders
        w2 = $urandom();
        model_idle(1);
        model_frame(w0);
        model_frame(32'd0);
        model_frame(w1);
        // word, zero frame, second word, then reset in bit 9 of the second word
        for (int c = 0; c < 43; c++) begin
            drive(1'b1, (c == 0) || (c >= 32), (c < 32) ? w0 : w1, 1'b0);
            @(negedge clk);
            e_cnt = (c >= 17) ? 16'd1 : 16'd0;
            ev_a = {(c == 0) || (c == 16) || (c == 32), c == 16, exp_a.pop_front(), e_cnt};
            ev_b = {(c == 0) || (c == 16) || (c == 32), c == 16, exp_b.pop_front(), e_cnt};
            checks++;
            if (obs_a !== ev_a) begin
                errors++;
                $display("FAIL pre_rst[%0d] dut_a rdy,uf,busy,stb,i,q=%b cnt=%h expected %b cnt=%h", c, obs_a[21:16], obs_a[15:0], ev_a[21:16], ev_a[15:0]);
            end
            checks++;
            if (obs_b !== ev_b) begin
                errors++;
                $display("FAIL pre_rst[%0d] dut_b rdy,uf,busy,stb,i,q=%b cnt=%h expected %b cnt=%h", c, obs_b[21:16], obs_b[15:0], ev_b[21:16], ev_b[15:0]);
            end
        end
        exp_a.delete();
        exp_b.delete();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs_a !== 22'd0) begin
            errors++;
            $display("FAIL rst_async dut_a rdy,uf,busy,stb,i,q=%b cnt=%h expected all zero", obs_a[21:16], obs_a[15:0]);
        end
        checks++;
        if (obs_b !== 22'd0) begin
            errors++;
            $display("FAIL rst_async dut_b rdy,uf,busy,stb,i,q=%b cnt=%h expected all zero", obs_b[21:16], obs_b[15:0]);
        end
        // two cycles in reset, release, then acceptance on the second edge
        model_idle(4);
        model_frame(w2);
        model_idle(3);
        for (int c = 0; c < 23; c++) begin
            drive(c <= 3, c <= 3, w2, 1'b0);
            rst = (c < 2);
            @(negedge clk);
            ev_a = {c == 3, 1'b0, exp_a.pop_front(), 16'h0000};
            ev_b = {c == 3, 1'b0, exp_b.pop_front(), 16'h0000};
            checks++;
            if (obs_a !== ev_a) begin
                errors++;
                $display("FAIL post_rst[%0d] dut_a rdy,uf,busy,stb,i,q=%b cnt=%h expected %b cnt=%h", c, obs_a[21:16], obs_a[15:0], ev_a[21:16], ev_a[15:0]);
            end
            checks++;
            if (obs_b !== ev_b) begin
                errors++;
                $display("FAIL post_rst[%0d] dut_b rdy,uf,busy,stb,i,q=%b cnt=%h expected %b cnt=%h", c, obs_b[21:16], obs_b[15:0], ev_b[21:16], ev_b[15:0]);
            end
        end
    endtask

`ifdef ADRV9001_SSI_SER_RAMP_EN
    task automatic test_ramp();
        logic [15:0] r;
        logic [21:0] ev_a, ev_b;
        reset_dut();
        model_idle(1);
        for (int f = 0; f < 3; f++) begin
            r = 16'(f);
            model_frame({r, ~r});
        end
        model_idle(4);
        for (int c = 0; c < 53; c++) begin
            drive(c <= 32, 1'b1, $urandom(), 1'b1);
            @(negedge clk);
            ev_a = {1'b0, 1'b0, exp_a.pop_front(), 16'h0000};
            ev_b = {1'b0, 1'b0, exp_b.pop_front(), 16'h0000};
            checks++;
            if (obs_a !== ev_a) begin
                errors++;
                $display("FAIL ramp[%0d] dut_a rdy,uf,busy,stb,i,q=%b cnt=%h expected %b cnt=%h", c, obs_a[21:16], obs_a[15:0], ev_a[21:16], ev_a[15:0]);
            end
            checks++;
            if (obs_b !== ev_b) begin
                errors++;
                $display("FAIL ramp[%0d] dut_b rdy,uf,busy,stb,i,q=%b cnt=%h expected %b cnt=%h", c, obs_b[21:16], obs_b[15:0], ev_b[21:16], ev_b[15:0]);
            end
        end
        test_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underflow();
        test_enable();
        test_reset_mid_frame();
`ifdef ADRV9001_SSI_SER_RAMP_EN
        test_ramp();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adrv9001_ssi_serializer.md
ADRV9001_SSI_SERIALIZER -- requirements
Module: adrv9001_ssi_serializer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, meaning 1 = lane bit 15 sent first and 0 = bit 0 sent first.
REQ-002 SHALL have parameter STROBE_LONG, default 0, meaning 0 = strobe high for the first bit of a frame only and 1 = strobe high for the first 8 bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, one serial bit per cycle; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port enable, input, 1 bit: channel enable, level-sensitive.
REQ-006 SHALL have port s_axis_tdata, input, 32 bits: I sample in [31:16], Q sample in [15:0], two's complement.
REQ-007 SHALL have port s_axis_tvalid, input, 1 bit: the sample word is valid.
REQ-008 SHALL have port s_axis_tready, output, 1 bit: the block accepts the word this cycle.
REQ-009 SHALL have port test_mode, input, 1 bit: select the internal ramp source (see Configuration).
REQ-010 SHALL have port strobe, output, 1 bit: SSI frame strobe.
REQ-011 SHALL have port idata, output, 1 bit: serial I lane.
REQ-012 SHALL have port qdata, output, 1 bit: serial Q lane.
REQ-013 SHALL have port busy, output, 1 bit: high while a frame is being shifted.
REQ-014 SHALL have port underflow, output, 1 bit: one-cycle pulse when a zero frame is inserted.
REQ-015 SHALL have port underflow_cnt, output, 16 bits: saturating count of inserted zero frames.

Function
REQ-016 SHALL implement FSM states IDLE and SHIFT, with a 4-bit bit counter bit_cnt.
REQ-017 SHALL assert s_axis_tready when (IDLE and enable) or (SHIFT and bit_cnt==15 and enable); it is combinational from the state.
REQ-018 SHALL latch tdata into the I/Q shift registers on tvalid&tready, enter SHIFT, and clear bit_cnt.
REQ-019 SHALL drive the first bit and strobe on the registered outputs in the cycle after acceptance (latency 1).
REQ-020 SHALL make each frame exactly 16 cycles; with tvalid held high, frames SHALL be back-to-back with no gap cycles.
REQ-021 SHALL, when STROBE_LONG=0, drive strobe=1 at bit_cnt==0 only; when STROBE_LONG=1, drive strobe=1 for bit_cnt 0..7.
REQ-022 SHALL shift idata/qdata in the same cycles as strobe, in the order set by MSB_FIRST.
REQ-023 SHALL, at bit_cnt==15 with enable=1 and tvalid=0, load 0x00000000, continue SHIFT with normal strobe, pulse underflow for 1 cycle, and increment underflow_cnt, saturating at 0xFFFF.
REQ-024 SHALL, in IDLE with enable=1 and tvalid=0, remain in IDLE with no underflow; underflow applies only between frames.
REQ-025 SHALL, on enable deasserting mid-frame, complete the current frame, not accept a new word, and return to IDLE.
REQ-026 SHALL hold strobe, idata, qdata and underflow at 0 in IDLE; busy SHALL equal (state==SHIFT).
REQ-027 SHALL allow enable to reassert in the final bit of a frame; this continues seamlessly under REQ-017.

Reset
REQ-028 SHALL, on rst assertion, immediately clear to 0: state=IDLE, bit_cnt, shift registers, strobe, idata, qdata, busy, underflow, underflow_cnt, and the ramp counter.
REQ-029 SHALL, on rst mid-frame, abort the frame without completion, and SHALL NOT assert s_axis_tready while rst=1.
REQ-030 SHALL treat rst release as synchronous: the first acceptance is possible on the second clk edge after release.

Configuration
REQ-031 SHALL, with macro ADRV9001_SSI_SER_RAMP_EN defined and test_mode=1, ignore the stream (tready=0) and load each frame from a 16-bit ramp: I=ramp, Q=~ramp, ramp+1 per frame, wrapping 0xFFFF->0x0000, with no underflow counted.
REQ-032 SHALL, with ADRV9001_SSI_SER_RAMP_EN undefined, ignore test_mode and synthesize no ramp logic.

Verification
REQ-033 SHALL test: rst low, enable=1, one word 0x8001_7FFE, MSB_FIRST=1 -> idata 1,0..0,1; qdata 0,1..1,0; strobe only on bit 0; then IDLE.
REQ-034 SHALL test: 4 words, tvalid held high -> 64 contiguous busy cycles, strobe every 16 cycles, tready pulses at cycles 0,16,32,48.
REQ-035 SHALL test: tvalid dropped after word 1, enable=1 -> second frame all zeros with strobe, underflow pulse at bit_cnt 15 of frame 1, underflow_cnt=1.
REQ-036 SHALL test: enable=0 at bit 5 of a frame -> frame completes at 16 bits, no tready, IDLE with outputs 0.
REQ-037 SHALL test: rst pulsed at bit 9 -> outputs 0 in the same cycle, underflow_cnt=0, restart with a clean frame.
REQ-038 SHALL test: macro defined, test_mode=1, STROBE_LONG=1 -> frames I=0x0000,0x0001,0x0002 with Q inverted, strobe high 8 cycles per frame.
